// File: rtl/mmul_multich_ctrl_fsm_pkg.sv
// rtl/mmul_multich_ctrl_fsm_pkg.sv - shared types and constants for the multi-channel MMUL controller
package mmul_multich_package;

   localparam int unsigned CNT_LEN_DEFAULT = 1024;

   // Config fields are sized for the widest supported build; the top narrows them on output.
   localparam int unsigned CFG_NB_ITER_W = 32;
   localparam int unsigned CFG_LEN_W     = 32;
   localparam int unsigned CFG_SHIFT_W   = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      START,
      COMPUTE,
      UPDATEIDX,
      TERMINATE
   } state_fsm_t;

   typedef struct packed {
      logic [CFG_NB_ITER_W-1:0] nb_iter;
      logic [CFG_LEN_W-1:0]     len;
      logic [CFG_SHIFT_W-1:0]   shift;
      logic                     simple_mul;
   } ctrl_fsm_cfg_t;

endpackage

// File: rtl/mmul_multich_ctrl_fsm_done_tracker.sv
// rtl/mmul_multich_ctrl_fsm_done_tracker.sv - sticky per-channel done flags with same-cycle all-done
module mmul_done_tracker #(
   parameter int unsigned N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [N-1:0] done_i,
   output logic         all_done_o
);

   logic [N-1:0] r_sticky;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sticky <= '0;
      end else if (clear_i) begin
         r_sticky <= '0;
      end else if (en_i) begin
         r_sticky <= r_sticky | done_i;
      end
   end

   // Incoming pulses count immediately so the last done does not cost an extra cycle.
   assign all_done_o = &(r_sticky | done_i);

endmodule

// File: rtl/mmul_multich_ctrl_fsm.sv
// rtl/mmul_multich_ctrl_fsm.sv - multi-iteration, multi-channel MMUL streamer/engine sequencer
// Optional COMPUTE watchdog enabled by defining MMUL_FSM_TIMEOUT_EN.
module mmul_multich_ctrl_fsm
   import mmul_multich_package::*;
#(
   parameter int unsigned NB_IN          = 2,
   parameter int unsigned NB_OUT         = 1,
   parameter int unsigned CNT_LEN        = CNT_LEN_DEFAULT,
   parameter int unsigned NB_ITER_W      = 16,
   parameter int unsigned SHIFT_W        = 5,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   localparam int unsigned LEN_W         = $clog2(CNT_LEN) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [NB_ITER_W-1:0] nb_iter_i,
   input  logic [LEN_W-1:0]     len_i,
   input  logic [SHIFT_W-1:0]   shift_i,
   input  logic                 simple_mul_i,
   input  logic [NB_IN-1:0]     src_ready_start_i,
   input  logic [NB_IN-1:0]     src_done_i,
   input  logic [NB_OUT-1:0]    snk_ready_start_i,
   input  logic [NB_OUT-1:0]    snk_done_i,
   input  logic                 eng_done_i,
   output logic [NB_IN-1:0]     src_req_start_o,
   output logic [NB_OUT-1:0]    snk_req_start_o,
   output logic                 eng_start_o,
   output logic                 eng_clear_o,
   output logic                 eng_enable_o,
   output logic [LEN_W-1:0]     eng_len_o,
   output logic [SHIFT_W-1:0]   eng_shift_o,
   output logic                 eng_simple_mul_o,
   output logic [NB_ITER_W-1:0] iter_idx_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
);

   if (NB_IN < 1 || NB_IN > 8 || NB_OUT < 1 || NB_OUT > 8 || TIMEOUT_CYCLES < 1 ||
       NB_ITER_W > CFG_NB_ITER_W || LEN_W > CFG_LEN_W || SHIFT_W > CFG_SHIFT_W) begin : g_bad_cfg
      $error("mmul_multich_ctrl_fsm: unsupported parameter set");
   end

   state_fsm_t           r_state, w_next;
   ctrl_fsm_cfg_t        r_cfg;
   logic [NB_ITER_W-1:0] r_iter;
   logic                 w_all_done, w_last, w_cfg_zero, w_ready, w_timeout;

   assign w_cfg_zero = (nb_iter_i == '0) || (len_i == '0);
   assign w_ready    = (&src_ready_start_i) && (&snk_ready_start_i);
   // Full-width compare: nb_iter is never 0 here, so the decrement cannot wrap.
   assign w_last     = (r_iter == NB_ITER_W'(r_cfg.nb_iter) - NB_ITER_W'(1));

   mmul_done_tracker #(
      .N (NB_IN + NB_OUT + 1)
   ) i_done_tracker (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i || (r_state == START)),
      .en_i       (r_state == COMPUTE),
      .done_i     ({eng_done_i, snk_done_i, src_done_i}),
      .all_done_o (w_all_done)
   );

`ifdef MMUL_FSM_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || r_state != COMPUTE) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
   end

   assign w_timeout = (r_state == COMPUTE) && !w_all_done &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i || (r_state == IDLE && start_i)) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   assign w_timeout = 1'b0;
   assign err_o     = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (start_i) w_next = w_cfg_zero ? TERMINATE : WAIT;
         WAIT:      if (w_ready) w_next = START;
         START:     w_next = COMPUTE;
         COMPUTE: begin
            if (w_all_done) begin
               w_next = UPDATEIDX;
            end else if (w_timeout) begin
               w_next = TERMINATE;
            end
         end
         UPDATEIDX: w_next = w_last ? TERMINATE : WAIT;
         TERMINATE: w_next = IDLE;
         default:   w_next = IDLE;
      endcase
      if (clear_i) w_next = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cfg  <= '0;
         r_iter <= '0;
      end else if (clear_i) begin
         r_iter <= '0;
      end else if (r_state == IDLE && start_i) begin
         r_cfg  <= '{nb_iter:    CFG_NB_ITER_W'(nb_iter_i),
                     len:        CFG_LEN_W'(len_i),
                     shift:      CFG_SHIFT_W'(shift_i),
                     simple_mul: simple_mul_i};
         r_iter <= '0;
      end else if (r_state == UPDATEIDX && !w_last) begin
         r_iter <= r_iter + NB_ITER_W'(1);
      end
   end

   always_comb begin
      src_req_start_o = '0;
      snk_req_start_o = '0;
      eng_start_o     = 1'b0;
      eng_enable_o    = 1'b0;
      done_o          = 1'b0;
      eng_clear_o     = rst_ni && clear_i;
      busy_o          = (r_state != IDLE);
      case (r_state)
         START: begin
            src_req_start_o = '1;
            snk_req_start_o = '1;
            eng_start_o     = 1'b1;
         end
         COMPUTE:   eng_enable_o = 1'b1;
         TERMINATE: begin
            done_o      = !clear_i;
            eng_clear_o = rst_ni;
         end
         default: ;
      endcase
   end

   assign eng_len_o        = LEN_W'(r_cfg.len);
   assign eng_shift_o      = SHIFT_W'(r_cfg.shift);
   assign eng_simple_mul_o = r_cfg.simple_mul;
   assign iter_idx_o       = r_iter;

endmodule

// File: tb/tb_mmul_multich_ctrl_fsm.sv
// tb/tb_mmul_multich_ctrl_fsm.sv - self-checking bench for mmul_multich_ctrl_fsm (default parameters)
module tb_mmul_multich_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_ni, clear_i, start_i;
   logic [15:0] nb_iter_i;
   logic [10:0] len_i;
   logic [4:0]  shift_i;
   logic        simple_mul_i;
   logic [1:0]  src_ready_start_i, src_done_i;
   logic [0:0]  snk_ready_start_i, snk_done_i;
   logic        eng_done_i;
   logic [1:0]  src_req_start_o;
   logic [0:0]  snk_req_start_o;
   logic        eng_start_o, eng_clear_o, eng_enable_o;
   logic [10:0] eng_len_o;
   logic [4:0]  eng_shift_o;
   logic        eng_simple_mul_o;
   logic [15:0] iter_idx_o;
   logic        busy_o, done_o, err_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mmul_multich_ctrl_fsm dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .clear_i           (clear_i),
      .start_i           (start_i),
      .nb_iter_i         (nb_iter_i),
      .len_i             (len_i),
      .shift_i           (shift_i),
      .simple_mul_i      (simple_mul_i),
      .src_ready_start_i (src_ready_start_i),
      .src_done_i        (src_done_i),
      .snk_ready_start_i (snk_ready_start_i),
      .snk_done_i        (snk_done_i),
      .eng_done_i        (eng_done_i),
      .src_req_start_o   (src_req_start_o),
      .snk_req_start_o   (snk_req_start_o),
      .eng_start_o       (eng_start_o),
      .eng_clear_o       (eng_clear_o),
      .eng_enable_o      (eng_enable_o),
      .eng_len_o         (eng_len_o),
      .eng_shift_o       (eng_shift_o),
      .eng_simple_mul_o  (eng_simple_mul_o),
      .iter_idx_o        (iter_idx_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .err_o             (err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      start_i           = 1'b0;
      clear_i           = 1'b0;
      src_done_i        = '0;
      snk_done_i        = '0;
      eng_done_i        = 1'b0;
      src_ready_start_i = '1;
      snk_ready_start_i = '1;
   endtask

   // One job: done pulses arrive dN cycles after each engine start; the reference is the
   // cycle-level schedule WAIT(1) + START(1) + COMPUTE(max d) + UPDATEIDX(1) per iteration.
   task automatic run_job(input string tag, input int nb, input int ln, input int d0, input int d1,
                          input int d2, input int d3, input int snk_low, input int clr_iter,
                          input int budget);
      int s_cur, first_req, done_cyc, clr_cyc, n_req, n_any, n_eng, n_done, en_cyc, m, s_exp;
      bit finished, zero;
      int idx_q[$];
      logic [4:0] sh;
      logic       sm;
      s_cur = -1000; first_req = -1; done_cyc = -1; clr_cyc = -1;
      n_req = 0; n_any = 0; n_eng = 0; n_done = 0; en_cyc = 0; finished = 0;
      zero = (nb == 0) || (ln == 0);
      sh = 5'($urandom);
      sm = 1'($urandom);
      m = d0;
      if (d1 > m) m = d1;
      if (d2 > m) m = d2;
      if (d3 > m) m = d3;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         @(negedge clk);
         start_i           = (cyc == 0);
         nb_iter_i         = 16'(nb);
         len_i             = 11'(ln);
         shift_i           = sh;
         simple_mul_i      = sm;
         src_ready_start_i = '1;
         snk_ready_start_i = (cyc >= snk_low);
         src_done_i        = {cyc == s_cur + d1, cyc == s_cur + d0};
         snk_done_i        = (cyc == s_cur + d2);
         eng_done_i        = (cyc == s_cur + d3);
         clear_i           = (cyc == clr_cyc);
         #1;
         if (clear_i) begin
            chk({tag, ".clr_eng_clear"}, eng_clear_o, 1);
            chk({tag, ".clr_no_done"}, done_o, 0);
         end
         if (clr_cyc >= 0 && cyc == clr_cyc + 1) begin
            chk({tag, ".clr_busy"}, busy_o, 0);
            chk({tag, ".clr_iter"}, iter_idx_o, 0);
            chk({tag, ".clr_enable"}, eng_enable_o, 0);
            finished = 1;
         end
         if (src_req_start_o == 2'b11 && snk_req_start_o == 1'b1) n_req++;
         if (src_req_start_o != '0 || snk_req_start_o != '0) n_any++;
         if (eng_start_o) begin
            n_eng++;
            s_cur = cyc;
            if (first_req < 0) first_req = cyc;
            idx_q.push_back(int'(iter_idx_o));
            if (clr_iter == int'(iter_idx_o)) clr_cyc = cyc + 2;
         end
         if (eng_enable_o) en_cyc++;
         if (done_o) begin
            n_done++;
            done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) begin
            chk({tag, ".busy_after"}, busy_o, 0);
            chk({tag, ".iter_final"}, iter_idx_o, zero ? 0 : nb - 1);
            chk({tag, ".len_latched"}, eng_len_o, ln);
            chk({tag, ".shift_latched"}, eng_shift_o, sh);
            chk({tag, ".mode_latched"}, eng_simple_mul_o, sm);
            finished = 1;
         end
      end
      drive_idle();
      chk({tag, ".finished"}, finished, 1);
      if (clr_iter >= 0) begin
         chk({tag, ".clr_done_cnt"}, n_done, 0);
         chk({tag, ".clr_starts"}, n_eng, clr_iter + 1);
      end else if (zero) begin
         chk({tag, ".zero_req"}, n_any, 0);
         chk({tag, ".zero_eng_start"}, n_eng, 0);
         chk({tag, ".zero_done_cnt"}, n_done, 1);
         chk({tag, ".zero_done_lat"}, (done_cyc >= 1 && done_cyc <= 2), 1);
      end else begin
         s_exp = ((snk_low > 1) ? snk_low : 1) + 1;
         chk({tag, ".req_all"}, n_req, nb);
         chk({tag, ".req_any"}, n_any, nb);
         chk({tag, ".eng_starts"}, n_eng, nb);
         chk({tag, ".done_cnt"}, n_done, 1);
         chk({tag, ".enable_cycles"}, en_cyc, nb * m);
         chk({tag, ".first_req_cyc"}, first_req, s_exp);
         chk({tag, ".done_cyc"}, done_cyc, s_exp + (nb - 1) * (m + 3) + m + 2);
         foreach (idx_q[i]) chk($sformatf("%s.idx%0d", tag, i), idx_q[i], i);
      end
   endtask

   initial begin
      int stuck_done;
      rst_ni       = 1'b0;
      nb_iter_i    = '0;
      len_i        = '0;
      shift_i      = '0;
      simple_mul_i = 1'b0;
      drive_idle();
      clear_i = 1'b1;
      start_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {src_req_start_o, snk_req_start_o, eng_start_o, eng_clear_o, eng_enable_o,
                            eng_len_o, eng_shift_o, eng_simple_mul_o, iter_idx_o, busy_o, done_o, err_o}, 0);
      drive_idle();
      rst_ni = 1'b1;
      @(negedge clk);

      run_job("basic", 3, 16, 5, 5, 5, 5, 0, -1, 2000);
      run_job("stagger", 2, 64, 3, 12, 10, 7, 0, -1, 2000);
      run_job("nb0", 0, 16, 1, 1, 1, 1, 0, -1, 50);
      run_job("len0", 2, 0, 1, 1, 1, 1, 0, -1, 50);
      run_job("clear", 3, 32, 5, 5, 5, 5, 0, 1, 2000);
      run_job("post_clr", 2, 8, 2, 4, 3, 1, 0, -1, 2000);
      run_job("snk_wait", 2, 16, 4, 4, 4, 4, 20, -1, 2000);
      for (int j = 0; j < 6; j++) begin
         run_job($sformatf("rnd%0d", j), int'($urandom_range(1, 4)), int'($urandom_range(1, 1023)),
                 int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                 int'($urandom_range(1, 12)), int'($urandom_range(0, 4)), -1, 2000);
      end

      // Engine never reports done: the controller must keep waiting in COMPUTE.
      stuck_done = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         start_i    = (c == 0);
         nb_iter_i  = 16'd2;
         len_i      = 11'd8;
         src_done_i = (c == 5) ? 2'b11 : 2'b00;
         snk_done_i = (c == 5);
         eng_done_i = 1'b0;
         #1;
         if (done_o) stuck_done++;
      end
      chk("stuck_done", stuck_done, 0);
      chk("stuck_err", err_o, 0);
      chk("stuck_enable", eng_enable_o, 1);
      chk("stuck_busy", busy_o, 1);
      @(negedge clk);
      drive_idle();
      clear_i = 1'b1;
      #1;
      chk("stuck_clear_pulse", eng_clear_o, 1);
      @(negedge clk);
      clear_i = 1'b0;
      #1;
      chk("stuck_clear_busy", busy_o, 0);

      // Reset in the middle of a job wipes state and latched config.
      @(negedge clk);
      nb_iter_i = 16'd3;
      len_i     = 11'd100;
      start_i   = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      rst_ni = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_len", eng_len_o, 0);
      chk("midrst_enable", eng_enable_o, 0);
      rst_ni = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
